// File: rtl/uart_rx_word_assembler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_word_assembler_pkg                                 |
// | Description : Shared definitions for the UART receive word assembler.    |
// |               Holds the default byte/word widths used by the receiver,   |
// |               the assembler and the loader, and the one-hot FSM state    |
// |               encodings.                                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package uart_rx_word_assembler_pkg;

   // Widths shared with the UART receiver and the debug/loader unit.
   localparam int c_NB_DATA_DEFAULT = 8;
   localparam int c_NB_WORD_DEFAULT = 32;

   // One-hot state encoding for the assembler FSM.
   localparam int c_NB_STATE = 3;
   typedef logic [c_NB_STATE-1:0] state_t;

   localparam state_t c_IDLE    = 3'b001;
   localparam state_t c_COLLECT = 3'b010;
   localparam state_t c_HOLD    = 3'b100;

   // Byte counter width. A single-byte word still needs a 1-bit vector so
   // that the counter declaration stays legal.
   function automatic int count_width(input int n_bytes);
      return (n_bytes > 1) ? $clog2(n_bytes) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_word_assembler_idle_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rx_idle_timer                                              |
// | Description : Inter-byte idle counter with expiry compare. Counts clocks |
// |               while i_run is high and no byte arrives; flags expiry when |
// |               the count reaches TIMEOUT_CYCLES-1.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   i_clock    in  1  system clock                                         |
// |   i_reset    in  1  asynchronous active-high reset                        |
// |   i_clear    in  1  restart the count (byte received or flush)            |
// |   i_run      in  1  counting enabled (assembler is collecting)            |
// |   o_expired  out 1  idle limit reached in this cycle                      |
// +--------------------------------------------------------------------------+
module rx_idle_timer #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int NB_TIMEOUT     = 20
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_run,
   output logic o_expired
);

   localparam logic [NB_TIMEOUT-1:0] c_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

   logic [NB_TIMEOUT-1:0] r_count;

   // Held at zero outside the collect phase so every new word starts fresh;
   // saturates at the limit so a stalled owner cannot wrap it around.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (!i_run || i_clear) begin
         r_count <= '0;
      end else if (r_count != c_LAST) begin
         r_count <= r_count + 1'b1;
      end
   end

   // A byte arriving in the expiry cycle suppresses the expiry.
   assign o_expired = i_run && !i_clear && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_word_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_word_assembler                                     |
// | Description : Packs N_BYTES = NB_WORD/NB_DATA received UART bytes into    |
// |               one little-endian word and offers it on a valid/ready      |
// |               handshake. Flags bytes lost while a word is held (sticky   |
// |               overrun) and, when RX_WORD_TIMEOUT_EN is defined, discards |
// |               a partial word after TIMEOUT_CYCLES idle clocks.           |
// | Config      : `define RX_WORD_TIMEOUT_EN enables the inter-byte timeout. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   i_clock    in  1        system clock, rising edge                      |
// |   i_reset    in  1        asynchronous active-high reset                 |
// |   i_rx_done  in  1        one-cycle byte strobe from the receiver        |
// |   i_rx_data  in  NB_DATA  received byte, valid with i_rx_done            |
// |   i_flush    in  1        synchronous clear of partial/held word & flags |
// |   i_ready    in  1        consumer accepts o_word with o_valid           |
// |   o_valid    out 1        o_word holds a complete word                   |
// |   o_word     out NB_WORD  assembled word, first byte in the LSBs         |
// |   o_overrun  out 1        sticky: a byte was dropped                     |
// |   o_timeout  out 1        one-cycle pulse: partial word discarded        |
// |   o_busy     out 1        FSM is not idle                                |
// +--------------------------------------------------------------------------+
module uart_rx_word_assembler
   import uart_rx_word_assembler_pkg::*;
#(
   parameter int NB_DATA        = c_NB_DATA_DEFAULT,
   parameter int NB_WORD        = c_NB_WORD_DEFAULT,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int NB_TIMEOUT     = 20
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_rx_done,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_flush,
   input  logic               i_ready,
   output logic               o_valid,
   output logic [NB_WORD-1:0] o_word,
   output logic               o_overrun,
   output logic               o_timeout,
   output logic               o_busy
);

   localparam int c_N_BYTES  = NB_WORD / NB_DATA;
   localparam int c_NB_COUNT = count_width(c_N_BYTES);

   localparam logic [c_NB_COUNT-1:0] c_LAST_SLOT   = c_NB_COUNT'(c_N_BYTES - 1);
   // Count after writing slot 0; a one-byte word is already complete.
   localparam logic [c_NB_COUNT-1:0] c_FIRST_COUNT = (c_N_BYTES > 1) ? c_NB_COUNT'(1) : '0;

   // Refuse to elaborate an inconsistent configuration.
   generate
      if ((NB_WORD < NB_DATA) || ((NB_WORD % NB_DATA) != 0) || (TIMEOUT_CYCLES < 1) ||
          ((64'd1 << NB_TIMEOUT) <= 64'(TIMEOUT_CYCLES))) begin : g_bad_config
         $error("uart_rx_word_assembler: inconsistent NB_DATA/NB_WORD/TIMEOUT parameters");
      end
   endgenerate

   state_t                  r_state;
   state_t                  w_state_next;
   logic [c_NB_COUNT-1:0]   r_count;
   logic [c_NB_COUNT-1:0]   w_count_next;
   logic [c_N_BYTES-1:0]    w_byte_en;
   logic                    w_overrun_set;
   logic                    r_overrun;

`ifdef RX_WORD_TIMEOUT_EN
   logic w_expired;
   logic w_timeout_set;
   logic r_timeout;

   rx_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .NB_TIMEOUT     (NB_TIMEOUT)
   ) u_idle_timer (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_clear   (i_rx_done || i_flush),
      .i_run     (r_state == c_COLLECT),
      .o_expired (w_expired)
   );

   assign o_timeout = r_timeout;
`else
   assign o_timeout = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic. Flush outranks every other event.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      if (i_flush) begin
         w_state_next = c_IDLE;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (i_rx_done) begin
                  w_state_next = (c_N_BYTES == 1) ? c_HOLD : c_COLLECT;
               end
            end
            c_COLLECT: begin
               if (i_rx_done) begin
                  if (r_count == c_LAST_SLOT) begin
                     w_state_next = c_HOLD;
                  end
`ifdef RX_WORD_TIMEOUT_EN
               end else if (w_expired) begin
                  w_state_next = c_IDLE;
`endif
               end
            end
            c_HOLD: begin
               // A byte arriving with the transfer starts the next word.
               if (i_ready) begin
                  if (i_rx_done) begin
                     w_state_next = (c_N_BYTES == 1) ? c_HOLD : c_COLLECT;
                  end else begin
                     w_state_next = c_IDLE;
                  end
               end
            end
            default: begin
               w_state_next = c_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // FSM: output / datapath control
   // ---------------------------------------------------------------------
   always_comb begin
      w_byte_en     = '0;
      w_count_next  = r_count;
      w_overrun_set = 1'b0;
`ifdef RX_WORD_TIMEOUT_EN
      w_timeout_set = 1'b0;
`endif
      if (i_flush) begin
         w_count_next = '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (i_rx_done) begin
                  w_byte_en[0] = 1'b1;
                  w_count_next = c_FIRST_COUNT;
               end
            end
            c_COLLECT: begin
               if (i_rx_done) begin
                  for (int s = 0; s < c_N_BYTES; s++) begin
                     if (r_count == c_NB_COUNT'(s)) begin
                        w_byte_en[s] = 1'b1;
                     end
                  end
                  w_count_next = (r_count == c_LAST_SLOT) ? '0 : r_count + 1'b1;
`ifdef RX_WORD_TIMEOUT_EN
               end else if (w_expired) begin
                  w_count_next  = '0;
                  w_timeout_set = 1'b1;
`endif
               end
            end
            c_HOLD: begin
               if (i_ready) begin
                  if (i_rx_done) begin
                     w_byte_en[0] = 1'b1;
                     w_count_next = c_FIRST_COUNT;
                  end else begin
                     w_count_next = '0;
                  end
               end else if (i_rx_done) begin
                  // Held word is frozen; the new byte is lost.
                  w_overrun_set = 1'b1;
               end
            end
            default: begin
               w_count_next = '0;
            end
         endcase
      end
   end

   assign o_valid   = (r_state == c_HOLD);
   assign o_busy    = (r_state != c_IDLE);
   assign o_overrun = r_overrun;

   // ---------------------------------------------------------------------
   // Counter and flags
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_count   <= w_count_next;
         r_overrun <= i_flush ? 1'b0 : (r_overrun | w_overrun_set);
      end
   end

`ifdef RX_WORD_TIMEOUT_EN
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_timeout_set;
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Byte-slot register file. Slots not yet rewritten keep stale data;
   // only o_valid qualifies o_word.
   // ---------------------------------------------------------------------
   generate
      for (genvar g = 0; g < c_N_BYTES; g++) begin : g_slot
         logic [NB_DATA-1:0] r_slot;

         always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
               r_slot <= '0;
            end else if (w_byte_en[g]) begin
               r_slot <= i_rx_data;
            end
         end

         assign o_word[g*NB_DATA +: NB_DATA] = r_slot;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_rx_word_assembler                                  |
// | Description : Self-checking bench for uart_rx_word_assembler. Expected   |
// |               words are queued as bytes are driven and compared when the |
// |               DUT transfers a word. Build with RX_WORD_TIMEOUT_EN to     |
// |               exercise the idle timeout.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_rx_word_assembler;

   logic        i_clock   = 1'b0;
   logic        i_reset   = 1'b1;
   logic        i_rx_done = 1'b0;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_flush   = 1'b0;
   logic        i_ready   = 1'b0;
   logic        o_valid;
   logic [31:0] o_word;
   logic        o_overrun;
   logic        o_timeout;
   logic        o_busy;

   logic [31:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   uart_rx_word_assembler #(
      .NB_DATA        (8),
      .NB_WORD        (32),
      .TIMEOUT_CYCLES (16),
      .NB_TIMEOUT     (5)
   ) dut (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_rx_done (i_rx_done),
      .i_rx_data (i_rx_data),
      .i_flush   (i_flush),
      .i_ready   (i_ready),
      .o_valid   (o_valid),
      .o_word    (o_word),
      .o_overrun (o_overrun),
      .o_timeout (o_timeout),
      .o_busy    (o_busy)
   );

   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_done = 1'b1;
      i_rx_data = b;
      tick();
      i_rx_done = 1'b0;
   endtask

   // Scoreboard: every transfer must match the oldest queued word.
   always @(negedge i_clock) begin
      if (!i_reset && o_valid && i_ready) begin
         logic [31:0] e;
         if (exp_q.size() != 0) e = exp_q.pop_front();
         else                   e = 32'hxxxxxxxx;
         check("transfer_word", o_word, e);
      end
   end

   initial begin
      int pulses;

      // Reset state
      repeat (3) tick();
      check("rst_valid",   o_valid,   0);
      check("rst_word",    o_word,    0);
      check("rst_overrun", o_overrun, 0);
      check("rst_timeout", o_timeout, 0);
      check("rst_busy",    o_busy,    0);
      i_reset = 1'b0;
      tick();

      // 1: straight word with consumer ready; valid 1 cycle after last strobe
      i_ready = 1'b1;
      exp_q.push_back(32'h44332211);
      send_byte(8'h11);
      send_byte(8'h22);
      check("t1_busy", o_busy, 1);
      send_byte(8'h33);
      check("t1_valid_early", o_valid, 0);
      send_byte(8'h44);
      check("t1_valid", o_valid, 1);
      check("t1_word",  o_word,  32'h44332211);
      tick();
      check("t1_valid_drop", o_valid, 0);
      check("t1_busy_idle",  o_busy,  0);

      // 2: held word, extra byte overruns, flush clears
      i_ready = 1'b0;
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      repeat (2) tick();
      check("t2_valid_held", o_valid, 1);
      send_byte(8'h55);
      check("t2_overrun",    o_overrun, 1);
      check("t2_word_frozen", o_word,   32'h44332211);
      check("t2_valid_still", o_valid,  1);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      check("t2_flush_valid",   o_valid,   0);
      check("t2_flush_overrun", o_overrun, 0);
      check("t2_flush_busy",    o_busy,    0);

      // 3: transfer and next first byte in the same cycle
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      exp_q.push_back(32'h04030201);
      i_ready = 1'b1;
      send_byte(8'hAA);
      check("t3_valid_after", o_valid,   0);
      check("t3_busy_after",  o_busy,    1);
      check("t3_no_overrun",  o_overrun, 0);
      exp_q.push_back(32'hDDCCBBAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      send_byte(8'hDD);
      check("t3_word", o_word, 32'hDDCCBBAA);
      tick();

      // 4: reset mid-word aborts
      send_byte(8'h77);
      send_byte(8'h88);
      i_reset = 1'b1;
      #1;
      check("t4_rst_busy",  o_busy,  0);
      check("t4_rst_valid", o_valid, 0);
      check("t4_rst_word",  o_word,  0);
      tick();
      i_reset = 1'b0;
      tick();
      exp_q.push_back(32'h04030201);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      check("t4_no_early_valid", o_valid, 0);
      send_byte(8'h04);
      check("t4_word", o_word, 32'h04030201);
      tick();

      // 5: inter-byte idle timeout
      send_byte(8'h10);
      send_byte(8'h20);
      pulses = 0;
      repeat (15) begin
         tick();
         pulses += int'(o_timeout);
      end
      check("t5_no_early_timeout", pulses, 0);
      tick();
`ifdef RX_WORD_TIMEOUT_EN
      check("t5_timeout_pulse", o_timeout, 1);
      check("t5_busy_after",    o_busy,    0);
      tick();
      check("t5_timeout_once",  o_timeout, 0);
`else
      check("t5_timeout_off",   o_timeout, 0);
      check("t5_still_busy",    o_busy,    1);
      tick();
      exp_q.push_back(32'h40302010);
      send_byte(8'h30);
      send_byte(8'h40);
      check("t5_late_word", o_word, 32'h40302010);
      tick();
`endif
      // Byte arriving exactly in the expiry cycle wins over the timeout
      exp_q.push_back(32'h0D0C0B0A);
      pulses = 0;
      send_byte(8'h0A);
      repeat (15) begin
         tick();
         pulses += int'(o_timeout);
      end
      send_byte(8'h0B);
      pulses += int'(o_timeout);
      send_byte(8'h0C);
      send_byte(8'h0D);
      check("t5_expiry_byte_wins", pulses, 0);
      check("t5_expiry_word", o_word, 32'h0D0C0B0A);
      tick();

      // 6: flush together with the final byte
      send_byte(8'hE1);
      send_byte(8'hE2);
      send_byte(8'hE3);
      i_flush = 1'b1;
      send_byte(8'hE4);
      i_flush = 1'b0;
      check("t6_valid",   o_valid,   0);
      check("t6_overrun", o_overrun, 0);
      check("t6_busy",    o_busy,    0);
      tick();
      check("t6_valid_later", o_valid, 0);

      repeat (2) tick();
      check("pending_words", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
